imem_loader: RTL

//   Byte-stream program loader upstream of the processor/imem/dmem/regfile wrapper.
//   - Receives a framed program over an 8-bit valid/ready stream.
//   - Assembles 32-bit words and writes them to instruction memory at sequential addresses.
//   - Holds the processor in reset until the image loads and its checksum passes.

---
 rtl/imem_loader_if.sv | 13 +
 rtl/imem_loader.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream handshake between a program source and the imem loader.
//   rx_data  : stream byte
//   rx_valid : rx_data valid (driven by the source)
//   rx_ready : sink accepts a byte this cycle (driven by the loader)
// A byte moves on every rising clock edge where rx_valid & rx_ready.
interface imem_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/imem_loader.sv
// Program loader: receives a framed image over an 8-bit stream, assembles
// little-endian 32-bit words, writes them to imem at sequential addresses and
// holds the processor in reset until the image checksum passes.
// Frame: LEN_LO, LEN_HI (word count N), 4*N payload bytes, CHK (XOR of all
// preceding frame bytes).
// Ports:
//   clock, reset    : clock and synchronous active-high reset
//   start           : pulse, begins a new load from IDLE/DONE/ERROR
//   rx              : byte stream (slave side)
//   mem_addr/data   : imem write address/data, held between writes
//   mem_wren        : one-cycle write strobe per assembled word
//   proc_reset      : processor reset request, low only in DONE
//   busy/done/err   : load in progress / load released / load failed
module imem_loader #(
  parameter int ADDR_WIDTH    = 12,
  parameter int BASE_ADDR     = 0,
  parameter int RELEASE_DELAY = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  imem_loader_if.slave          rx,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_data,
  output logic                  mem_wren,
  output logic                  proc_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [31:0]           MAX_WORDS = 32'((1 << ADDR_WIDTH) - BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] BASE_V    = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [15:0]           REL_LAST  = 16'(RELEASE_DELAY - 1);

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, WORD, CHECK, RELEASE, DONE, ERROR
  } state_t;

  state_t                state;
  logic [15:0]           len;
  logic [7:0]            xsum;
  logic [15:0]           word_idx;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [1:0]            byte_cnt;
  logic [23:0]           asm_lo;
  logic [15:0]           rel_cnt;
  logic                  accept;
  logic [15:0]           n_full;

  assign accept = rx.rx_valid & rx.rx_ready;
  assign n_full = {rx.rx_data, len[7:0]};

  // rx_ready and the status flags are registered alongside the state so they
  // always reflect the state being entered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      rx.rx_ready <= 1'b0;
      mem_wren    <= 1'b0;
      mem_addr    <= '0;
      mem_data    <= '0;
      proc_reset  <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      len         <= '0;
      xsum        <= '0;
      word_idx    <= '0;
      waddr       <= BASE_V;
      byte_cnt    <= '0;
      asm_lo      <= '0;
      rel_cnt     <= '0;
    end else begin
      mem_wren <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state       <= LEN_LO;
            rx.rx_ready <= 1'b1;
            busy        <= 1'b1;
            proc_reset  <= 1'b1;
            done        <= 1'b0;
            err         <= 1'b0;
            xsum        <= '0;
            word_idx    <= '0;
            waddr       <= BASE_V;
            byte_cnt    <= '0;
          end
        end
        LEN_LO: begin
          if (accept) begin
            len[7:0] <= rx.rx_data;
            xsum     <= xsum ^ rx.rx_data;
            state    <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (accept) begin
            len[15:8] <= rx.rx_data;
            xsum      <= xsum ^ rx.rx_data;
            if (n_full == 16'd0) begin
              state <= CHECK;
            end else if ({16'd0, n_full} > MAX_WORDS) begin
              state       <= ERROR;
              rx.rx_ready <= 1'b0;
              busy        <= 1'b0;
              err         <= 1'b1;
            end else begin
              state <= WORD;
            end
          end
        end
        WORD: begin
          if (accept) begin
            xsum     <= xsum ^ rx.rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: asm_lo[7:0]   <= rx.rx_data;
              2'd1: asm_lo[15:8]  <= rx.rx_data;
              2'd2: asm_lo[23:16] <= rx.rx_data;
              default: begin
                mem_wren <= 1'b1;
                mem_addr <= waddr;
                mem_data <= {rx.rx_data, asm_lo};
                waddr    <= waddr + 1'b1;
                word_idx <= word_idx + 16'd1;
                if (word_idx == len - 16'd1) state <= CHECK;
              end
            endcase
          end
        end
        CHECK: begin
          if (accept) begin
            rx.rx_ready <= 1'b0;
            if (rx.rx_data == xsum) begin
              state   <= RELEASE;
              rel_cnt <= '0;
            end else begin
              state <= ERROR;
              busy  <= 1'b0;
              err   <= 1'b1;
            end
          end
        end
        RELEASE: begin
          if (rel_cnt == REL_LAST) begin
            state      <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            proc_reset <= 1'b0;
          end else begin
            rel_cnt <= rel_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
